pokey_kb_scan: RTL and testbench
================================

POKEY_KB_SCAN -- requirements
Module: pokey_kb_scan

Interface
REQ-001 SHALL: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: scan_tick  input  1  one-clk strobe; one scan step per strobe (15.7 kHz rate).
REQ-004 SHALL: scan_en  input  1  keyboard scan enable (SKCTL bit 1).
REQ-005 SHALL: debounce_en  input  1  debounce enable (SKCTL bit 0).
REQ-006 SHALL: kr1_n  input  1  keypad return line, low = key at current scan position closed.
REQ-007 SHALL: k_scan  output  4  current scan position driven to keypad matrix.
REQ-008 SHALL: keycode_latch  output  4  last accepted scan position; feeds the KBCODE remap stage.
REQ-009 SHALL: key_valid  output  1  one-clk pulse on each accepted key (KBCODE IRQ request).
REQ-010 SHALL: key_down  output  1  level, key held (SKSTAT key-depressed bit).

Function
REQ-011 SHALL: scan counter (k_scan) 4-bit, increments 15 -> 0 wrap on each scan_tick while scan_en=1.
REQ-012 SHALL: on each scan_tick, sample pressed = ~kr1_n for position k_scan before increment.
REQ-013 SHALL: position 0 is "no key"; a press sampled at position 0 is ignored in every state.
REQ-014 SHALL: FSM states IDLE, CAPTURE, HELD, RELCHK; cmp register (4 bit) holds candidate position.
REQ-015 SHALL: IDLE, press at p!=0, debounce_en=1 -> cmp<=p, CAPTURE.
REQ-016 SHALL: IDLE, press at p!=0, debounce_en=0 -> cmp<=p, keycode_latch<=p, key_valid pulse, key_down<=1, HELD.
REQ-017 SHALL: CAPTURE, tick at position cmp pressed -> keycode_latch<=cmp, key_valid pulse, key_down<=1, HELD; not pressed -> IDLE.
REQ-018 SHALL: HELD, tick at position cmp not pressed -> RELCHK if debounce_en=1, else IDLE with key_down<=0.
REQ-019 SHALL: RELCHK, tick at position cmp pressed -> HELD; not pressed -> IDLE, key_down<=0.
REQ-020 SHALL: in CAPTURE/HELD/RELCHK, samples at positions != cmp are ignored (first-key lockout, no rollover).
REQ-021 SHALL: key_valid asserts the clk after the qualifying scan_tick, exactly one clk wide; key_down updates on that same edge.
REQ-022 SHALL: scan_en=0 -> counter holds, FSM forced to IDLE, key_down<=0, key_valid=0, keycode_latch retained; scan_en wins over simultaneous scan_tick.
REQ-023 SHALL: debounce_en change mid-sequence takes effect at the next scan_tick evaluation; no spurious key_valid.
REQ-024 SHALL: repeat of the same held key never re-pulses key_valid until a release reaches IDLE.

Reset
REQ-025 SHALL: rst_n low -> k_scan=0, keycode_latch=0, cmp=0, key_valid=0, key_down=0, FSM=IDLE, synchronizer flops=1, asynchronously.
REQ-026 SHALL: reset mid-debounce discards the candidate; no key_valid after release of reset until a fresh accept.

Configuration
REQ-027 SHALL: POKEY_KB_SYNC_EN defined -> kr1_n passes a 2-flop synchronizer (reset to 1) before sampling; samples then refer to the scan position two clks earlier, and scan_tick spacing of >=3 clks is required.
REQ-028 SHALL: POKEY_KB_SYNC_EN undefined -> kr1_n sampled directly at scan_tick; no added latency.

Structure
REQ-029 SHALL: shared package pokey_pkg holds FSM state enum (IDLE, CAPTURE, HELD, RELCHK), KB_POS_W=4, KB_NOKEY=4'h0.
REQ-030 SHALL: one sub-module, pokey_kb_sync (2-flop synchronizer), instantiated only under POKEY_KB_SYNC_EN.

Verification
REQ-031 SHALL: debounce_en=1, hold kr1_n low at position 5 for two passes -> keycode_latch=5, one key_valid pulse on second pass, key_down=1.
REQ-032 SHALL: debounce_en=1, kr1_n low at position 9 for one pass only -> back to IDLE, no key_valid, keycode_latch unchanged.
REQ-033 SHALL: debounce_en=0, press at position 3 -> key_valid on the first pass, keycode_latch=3; release one pass -> key_down=0.
REQ-034 SHALL: hold key 7, then also press key 12 -> keycode_latch stays 7; release 7 for two passes -> key_down=0; key 12 then accepted after two passes.
REQ-035 SHALL: press at position 0 for 4 passes -> no key_valid, key_down=0; k_scan wraps 15->0 continuously.
REQ-036 SHALL: assert rst_n low while in CAPTURE for key 6 -> all outputs 0 immediately; no key_valid within one pass after reset release.

Source files
------------

// File: rtl/pokey_pkg.sv
// rtl/pokey_pkg.sv - shared types and constants for the POKEY keyboard scanner
//
// Purpose: scan FSM state encoding, scan position width and the "no key"
// position shared by pokey_kb_scan and its helpers.
// Ports: none (package).
package pokey_pkg;

  localparam int KB_POS_W = 4;
  localparam logic [KB_POS_W-1:0] KB_NOKEY = 4'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HELD    = 2'd2,
    RELCHK  = 2'd3
  } kb_state_e;

endpackage

// File: rtl/pokey_kb_sync.sv
// rtl/pokey_kb_sync.sv - 2-flop synchronizer for the active-low keypad return line
//
// Purpose: brings the asynchronous kr1_n line into the clk domain. Both flops
// reset to 1 so a reset never looks like a closed key.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d_n    in   raw active-low return line
//   q_n    out  synchronized active-low return line (2 clk latency)
module pokey_kb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_n,
  output logic q_n
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_n;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_n = sync_q;

endmodule

// File: rtl/pokey_kb_scan.sv
// rtl/pokey_kb_scan.sv - POKEY keyboard matrix scanner with debounce FSM
//
// Purpose: walks a 4-bit scan position across the keypad on every scan_tick,
// samples the return line and accepts the first closed key (position 0 means
// "no key"). With debounce a key must be seen on two consecutive passes to be
// accepted and seen open on two consecutive passes to be released.
// Optional feature: define POKEY_KB_SYNC_EN to pass kr1_n through a 2-flop
// synchronizer before sampling (needs scan_tick spacing of >= 3 clks).
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   scan_tick      in   one-clk scan step strobe
//   scan_en        in   keyboard scan enable
//   debounce_en    in   debounce enable
//   kr1_n          in   keypad return, low = key at k_scan closed
//   k_scan         out  current scan position
//   keycode_latch  out  last accepted scan position
//   key_valid      out  one-clk pulse per accepted key
//   key_down       out  key held level
module pokey_kb_scan
  import pokey_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_tick,
  input  logic                scan_en,
  input  logic                debounce_en,
  input  logic                kr1_n,
  output logic [KB_POS_W-1:0] k_scan,
  output logic [KB_POS_W-1:0] keycode_latch,
  output logic                key_valid,
  output logic                key_down
);

  logic kr1_s_n;

`ifdef POKEY_KB_SYNC_EN
  pokey_kb_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_n   (kr1_n),
    .q_n   (kr1_s_n)
  );
`else
  assign kr1_s_n = kr1_n;
`endif

  kb_state_e           state_q, state_d;
  logic [KB_POS_W-1:0] k_scan_q, k_scan_d;
  logic [KB_POS_W-1:0] cmp_q, cmp_d;
  logic [KB_POS_W-1:0] latch_q, latch_d;
  logic                key_valid_q, key_valid_d;
  logic                key_down_q, key_down_d;

  logic pressed;
  logic at_cmp;
  logic real_key;

  // Samples always refer to the position before this tick's increment.
  assign pressed  = ~kr1_s_n;
  assign at_cmp   = (k_scan_q == cmp_q);
  assign real_key = pressed && (k_scan_q != KB_NOKEY);

  always_comb begin
    state_d     = state_q;
    k_scan_d    = k_scan_q;
    cmp_d       = cmp_q;
    latch_d     = latch_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    if (!scan_en) begin
      // Disable wins over a coincident tick; the latched code is kept.
      state_d    = IDLE;
      key_down_d = 1'b0;
    end else if (scan_tick) begin
      k_scan_d = k_scan_q + 4'd1;
      unique case (state_q)
        IDLE: begin
          if (real_key) begin
            cmp_d = k_scan_q;
            if (debounce_en) begin
              state_d = CAPTURE;
            end else begin
              latch_d     = k_scan_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = HELD;
            end
          end
        end
        // cmp is never 0 outside IDLE, so position 0 never matches here.
        CAPTURE: begin
          if (at_cmp) begin
            if (pressed) begin
              latch_d     = cmp_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (at_cmp && !pressed) begin
            if (debounce_en) begin
              state_d = RELCHK;
            end else begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end
          end
        end
        RELCHK: begin
          if (at_cmp) begin
            if (pressed) begin
              state_d = HELD;
            end else begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_scan_q    <= KB_NOKEY;
      cmp_q       <= KB_NOKEY;
      latch_q     <= KB_NOKEY;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_scan_q    <= k_scan_d;
      cmp_q       <= cmp_d;
      latch_q     <= latch_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign k_scan        = k_scan_q;
  assign keycode_latch = latch_q;
  assign key_valid     = key_valid_q;
  assign key_down      = key_down_q;

endmodule

// File: tb/tb_pokey_kb_scan.sv
// tb/tb_pokey_kb_scan.sv - self-checking bench for pokey_kb_scan
module tb_pokey_kb_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_tick = 1'b0;
  logic       scan_en = 1'b0;
  logic       debounce_en = 1'b0;
  logic       kr1_n;
  logic [3:0] k_scan;
  logic [3:0] keycode_latch;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys = 16'h0000;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic        prev_kv = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  // Keypad matrix model: return line low when the key at the scanned position is closed.
  assign kr1_n = ~keys[k_scan];

  pokey_kb_scan dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_tick     (scan_tick),
    .scan_en       (scan_en),
    .debounce_en   (debounce_en),
    .kr1_n         (kr1_n),
    .k_scan        (k_scan),
    .keycode_latch (keycode_latch),
    .key_valid     (key_valid),
    .key_down      (key_down)
  );

  // Scoreboard: every key_valid pulse must match the next expected code.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      vectors++;
      if (prev_kv) begin
        miscompares++;
        $display("FAIL kv_width: key_valid high %0d clks, required 1", 2);
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL kv_unexpected: key_valid with code %0d, required no pulse", keycode_latch);
      end else begin
        exp_code = exp_q.pop_front();
        if (keycode_latch !== exp_code) begin
          miscompares++;
          $display("FAIL kv_code: got %0d, required %0d", keycode_latch, exp_code);
        end
      end
    end
    prev_kv = key_valid;
  end

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 scan_tick = 1'b1;
      @(posedge clk); #1 scan_tick = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_passes(input int n);
    run_ticks(16 * n);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (k_scan !== 4'd0) begin miscompares++; $display("FAIL rst_k_scan: got %0d, required 0", k_scan); end
    vectors++; if (keycode_latch !== 4'd0) begin miscompares++; $display("FAIL rst_latch: got %0d, required 0", keycode_latch); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", key_valid); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rst_down: got %b, required 0", key_down); end
    rst_n = 1'b1;
    scan_en = 1'b1;
  endtask

  task automatic test_debounce_accept();
    debounce_en = 1'b1;
    keys = 16'h0001 << 5;
    exp_q.push_back(4'd5);
    run_passes(1);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL deb5_pass1_down: got %b, required 0", key_down); end
    run_passes(1);
    vectors++; if (keycode_latch !== 4'd5) begin miscompares++; $display("FAIL deb5_latch: got %0d, required 5", keycode_latch); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL deb5_down: got %b, required 1", key_down); end
    run_passes(2);
    keys = 16'h0000;
    run_passes(1);
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL deb5_relchk_down: got %b, required 1", key_down); end
    run_passes(1);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL deb5_release: got %b, required 0", key_down); end
  endtask

  task automatic test_debounce_reject();
    debounce_en = 1'b1;
    keys = 16'h0001 << 9;
    run_passes(1);
    keys = 16'h0000;
    run_passes(1);
    vectors++; if (keycode_latch !== 4'd5) begin miscompares++; $display("FAIL bounce9_latch: got %0d, required 5", keycode_latch); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL bounce9_down: got %b, required 0", key_down); end
  endtask

  task automatic test_no_debounce();
    debounce_en = 1'b0;
    keys = 16'h0001 << 3;
    exp_q.push_back(4'd3);
    run_passes(1);
    vectors++; if (keycode_latch !== 4'd3) begin miscompares++; $display("FAIL nodeb3_latch: got %0d, required 3", keycode_latch); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL nodeb3_down: got %b, required 1", key_down); end
    keys = 16'h0000;
    run_passes(1);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL nodeb3_release: got %b, required 0", key_down); end
  endtask

  task automatic test_lockout();
    debounce_en = 1'b1;
    keys = 16'h0001 << 7;
    exp_q.push_back(4'd7);
    run_passes(2);
    keys = (16'h0001 << 7) | (16'h0001 << 12);
    run_passes(2);
    vectors++; if (keycode_latch !== 4'd7) begin miscompares++; $display("FAIL lock_latch: got %0d, required 7", keycode_latch); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL lock_down: got %b, required 1", key_down); end
    keys = 16'h0001 << 12;
    run_passes(2);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL lock_rel7: got %b, required 0", key_down); end
    exp_q.push_back(4'd12);
    run_passes(2);
    vectors++; if (keycode_latch !== 4'd12) begin miscompares++; $display("FAIL lock_latch12: got %0d, required 12", keycode_latch); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL lock_down12: got %b, required 1", key_down); end
    keys = 16'h0000;
    run_passes(2);
  endtask

  task automatic test_pos0_wrap();
    debounce_en = 1'b1;
    keys = 16'h0001;
    run_ticks(15);
    vectors++; if (k_scan !== 4'd15) begin miscompares++; $display("FAIL wrap_15: got %0d, required 15", k_scan); end
    run_ticks(1);
    vectors++; if (k_scan !== 4'd0) begin miscompares++; $display("FAIL wrap_0: got %0d, required 0", k_scan); end
    run_passes(3);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL pos0_down: got %b, required 0", key_down); end
    vectors++; if (keycode_latch !== 4'd12) begin miscompares++; $display("FAIL pos0_latch: got %0d, required 12", keycode_latch); end
    debounce_en = 1'b0;
    run_passes(1);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL pos0_nodeb_down: got %b, required 0", key_down); end
    keys = 16'h0000;
  endtask

  task automatic test_scan_disable();
    debounce_en = 1'b0;
    keys = 16'h0001 << 4;
    exp_q.push_back(4'd4);
    run_passes(1);
    scan_en = 1'b0;
    run_ticks(5);
    vectors++; if (k_scan !== 4'd0) begin miscompares++; $display("FAIL dis_hold: got %0d, required 0", k_scan); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL dis_down: got %b, required 0", key_down); end
    vectors++; if (keycode_latch !== 4'd4) begin miscompares++; $display("FAIL dis_latch: got %0d, required 4", keycode_latch); end
    scan_en = 1'b1;
    exp_q.push_back(4'd4);
    run_passes(1);
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL reen_down: got %b, required 1", key_down); end
    keys = 16'h0000;
    run_passes(1);
  endtask

  task automatic test_reset_mid_capture();
    debounce_en = 1'b1;
    keys = 16'h0001 << 6;
    run_ticks(7);
    rst_n = 1'b0;
    #1;
    vectors++; if (k_scan !== 4'd0) begin miscompares++; $display("FAIL mrst_k_scan: got %0d, required 0", k_scan); end
    vectors++; if (keycode_latch !== 4'd0) begin miscompares++; $display("FAIL mrst_latch: got %0d, required 0", keycode_latch); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL mrst_down: got %b, required 0", key_down); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid: got %b, required 0", key_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_passes(1);
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL mrst_pass_down: got %b, required 0", key_down); end
    keys = 16'h0000;
    run_passes(1);
  endtask

  initial begin
    test_reset();
    test_debounce_accept();
    test_debounce_reject();
    test_no_debounce();
    test_lockout();
    test_pos0_wrap();
    test_scan_disable();
    test_reset_mid_capture();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected pulses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
